traffic_demand_timer: RTL and testbench

- Upstream timing planner for the crossroads light controller; generates the per-road green durations that the controller consumes as CA/CB.
- Counts vehicle-arrival pulses from one loop sensor per road during each signal cycle.
- On each controller entry into all-red, converts those counts into clamped green durations.
- Commits new durations only during all-red, so the controller never sees its terminal count change mid-phase.

---
 rtl/traffic_pkg.sv | 28 ++
 rtl/sensor_pulse_counter.sv | 62 ++++++
 rtl/traffic_demand_timer.sv | 167 ++++++++++++++++
 tb/tb_traffic_demand_timer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the crossroads timing planner: lamp codes, FSM states, widths.
package traffic_pkg;

  localparam int unsigned DUR_W = 8;
  localparam int unsigned CNT_W = 8;

  localparam logic [2:0] LAMP_G = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_R = 3'b001;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    CALC   = 2'd1,
    COMMIT = 2'd2
  } fsm_state_e;

  // Green durations handed to the light controller as one payload.
  typedef struct packed {
    logic [DUR_W-1:0] ca;
    logic [DUR_W-1:0] cb;
  } dur_pair_t;

  // True only when both roads show exactly the red code; illegal codes are not all-red.
  function automatic logic is_all_red(input logic [2:0] lamp_a, input logic [2:0] lamp_b);
    return (lamp_a == LAMP_R) && (lamp_b == LAMP_R);
  endfunction

endpackage

// File: rtl/sensor_pulse_counter.sv
// One road's loop sensor: synchroniser, rising-edge detect, holdoff and saturating count.
module sensor_pulse_counter
  import traffic_pkg::*;
#(
  parameter int unsigned HOLDOFF = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_sensor,
  input  logic             i_snap,
  output logic [CNT_W-1:0] o_count
);

  localparam int unsigned      HO_W    = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HO_W-1:0]  HO_LOAD = HO_W'(HOLDOFF - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       r_sync;
  logic             r_prev;
  logic [HO_W-1:0]  r_timer;
  logic [CNT_W-1:0] r_count;
  logic             w_edge;
  logic             w_take;

  assign w_edge  = r_sync[1] & ~r_prev;
  assign w_take  = w_edge && (r_timer == '0);
  assign o_count = r_count;

  // Two-flop synchroniser plus delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= 2'b00;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_sensor};
      r_prev <= r_sync[1];
    end
  end

  // Holdoff timer: reloaded by a counted edge, then runs down to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timer <= '0;
    end else if (w_take) begin
      r_timer <= HO_LOAD;
    end else if (r_timer != '0) begin
      r_timer <= r_timer - HO_W'(1);
    end
  end

  // Saturating count; a snapshot clears it, keeping an edge taken in that same clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_snap) begin
      r_count <= w_take ? CNT_W'(1) : '0;
    end else if (w_take && (r_count != CNT_MAX)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/traffic_demand_timer.sv
// Demand-based green duration planner; commits new CA/CB only on entry into all-red.
module traffic_demand_timer
  import traffic_pkg::*;
#(
  parameter int unsigned MIN_G   = 8,
  parameter int unsigned MAX_G   = 60,
  parameter int unsigned STEP    = 2,
  parameter int unsigned DEF_A   = 20,
  parameter int unsigned DEF_B   = 20,
  parameter int unsigned HOLDOFF = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sa,
  input  logic             sb,
  input  logic             mode,
  input  logic [2:0]       la,
  input  logic [2:0]       lb,
  output logic [DUR_W-1:0] ca,
  output logic [DUR_W-1:0] cb,
  output logic             upd
);

  localparam int unsigned       RAW_W     = 16;
  localparam logic [RAW_W-1:0]  RAW_MIN   = RAW_W'(MIN_G);
  localparam logic [RAW_W-1:0]  RAW_STEP  = RAW_W'(STEP);
  localparam logic [RAW_W-1:0]  RAW_MAX   = RAW_W'(MAX_G);
  localparam logic [DUR_W-1:0]  DUR_MAX   = DUR_W'(MAX_G);
  localparam logic [DUR_W-1:0]  DUR_DEF_A = DUR_W'(DEF_A);
  localparam logic [DUR_W-1:0]  DUR_DEF_B = DUR_W'(DEF_B);

  fsm_state_e       r_state;
  fsm_state_e       w_state_nxt;
  logic             w_snap;
  logic             w_calc;
  logic             w_commit;
  logic             w_rr;
  logic             r_rr_q;
  logic             w_rr_rise;
  logic [CNT_W-1:0] w_cnt_a;
  logic [CNT_W-1:0] w_cnt_b;
  logic [CNT_W-1:0] r_na;
  logic [CNT_W-1:0] r_nb;
  logic [RAW_W-1:0] r_raw_a;
  logic [RAW_W-1:0] r_raw_b;
  dur_pair_t        r_dur;
  logic             r_upd;

  function automatic logic [DUR_W-1:0] clamp_dur(input logic [RAW_W-1:0] raw);
    return (raw > RAW_MAX) ? DUR_MAX : raw[DUR_W-1:0];
  endfunction

  sensor_pulse_counter #(.HOLDOFF(HOLDOFF)) u_sens_a (
    .clk      (clk),
    .rst      (rst),
    .i_sensor (sa),
    .i_snap   (w_snap),
    .o_count  (w_cnt_a)
  );

  sensor_pulse_counter #(.HOLDOFF(HOLDOFF)) u_sens_b (
    .clk      (clk),
    .rst      (rst),
    .i_sensor (sb),
    .i_snap   (w_snap),
    .o_count  (w_cnt_b)
  );

  assign w_rr      = is_all_red(la, lb);
  assign w_rr_rise = w_rr & ~r_rr_q;
  assign ca        = r_dur.ca;
  assign cb        = r_dur.cb;
  assign upd       = r_upd;

  // All-red history for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_q <= 1'b0;
    end else begin
      r_rr_q <= w_rr;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and datapath strobes; all-red entries outside ACCUM are ignored.
  always_comb begin
    w_state_nxt = r_state;
    w_snap      = 1'b0;
    w_calc      = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      ACCUM: begin
        if (w_rr_rise) begin
          w_snap      = 1'b1;
          w_state_nxt = CALC;
        end
      end
      CALC: begin
        w_calc      = 1'b1;
        w_state_nxt = COMMIT;
      end
      COMMIT: begin
        w_commit    = 1'b1;
        w_state_nxt = ACCUM;
      end
      default: begin
        w_state_nxt = ACCUM;
      end
    endcase
  end

  // Snapshot of the window counts taken as the counters clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_na <= '0;
      r_nb <= '0;
    end else if (w_snap) begin
      r_na <= w_cnt_a;
      r_nb <= w_cnt_b;
    end
  end

  // Unclamped durations; 16 bits covers MIN_G + STEP*255 without overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_raw_a <= '0;
      r_raw_b <= '0;
    end else if (w_calc) begin
      r_raw_a <= RAW_MIN + RAW_STEP * RAW_W'(r_na);
      r_raw_b <= RAW_MIN + RAW_STEP * RAW_W'(r_nb);
    end
  end

  // Output durations change only in COMMIT, which is always inside all-red.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dur.ca <= DUR_DEF_A;
      r_dur.cb <= DUR_DEF_B;
    end else if (w_commit) begin
      if (mode) begin
        r_dur.ca <= DUR_DEF_A;
        r_dur.cb <= DUR_DEF_B;
      end else begin
        r_dur.ca <= clamp_dur(r_raw_a);
        r_dur.cb <= clamp_dur(r_raw_b);
      end
    end
  end

  // Update strobe marks the clock in which ca/cb take their new values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_upd <= 1'b0;
    end else begin
      r_upd <= w_commit;
    end
  end

endmodule

// File: tb/tb_traffic_demand_timer.sv
// Directed and randomized checks of traffic_demand_timer against a count-to-duration model.
module tb_traffic_demand_timer;
  import traffic_pkg::*;

  localparam int MIN_G = 8;
  localparam int MAX_G = 60;
  localparam int STEP  = 2;
  localparam int DEF_A = 20;
  localparam int DEF_B = 20;

  logic       clk  = 1'b0;
  logic       rst  = 1'b0;
  logic       sa   = 1'b0;
  logic       sb   = 1'b0;
  logic       mode = 1'b0;
  logic [2:0] la   = LAMP_G;
  logic [2:0] lb   = LAMP_R;
  logic [7:0] ca;
  logic [7:0] cb;
  logic       upd;

  int checks = 0;
  int errors = 0;
  int exp_ca = DEF_A;
  int exp_cb = DEF_B;

  always #5 clk = ~clk;

  traffic_demand_timer #(
    .MIN_G(MIN_G), .MAX_G(MAX_G), .STEP(STEP),
    .DEF_A(DEF_A), .DEF_B(DEF_B), .HOLDOFF(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sa  (sa),
    .sb  (sb),
    .mode(mode),
    .la  (la),
    .lb  (lb),
    .ca  (ca),
    .cb  (cb),
    .upd (upd)
  );

  // Reference: vehicles seen in a window -> clamped green, or the fixed default.
  function automatic int exp_dur(input int n, input bit fixed, input int def);
    int c;
    if (fixed) return def;
    c = (n > 255) ? 255 : n;
    c = MIN_G + STEP * c;
    return (c > MAX_G) ? MAX_G : c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input int expv);
    checks++;
    assert (obs === 32'(expv)) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // One sensor pulse, two clocks high, 'gap' clocks from rise to next possible rise.
  task automatic pulse(input bit road_a, input int gap);
    if (road_a) sa = 1'b1; else sb = 1'b1;
    repeat (2) @(negedge clk);
    if (road_a) sa = 1'b0; else sb = 1'b0;
    repeat (gap - 2) @(negedge clk);
  endtask

  task automatic pulses(input bit road_a, input int n, input int gmin, input int gmax);
    for (int i = 0; i < n; i++) pulse(road_a, int'($urandom_range(gmax, gmin)));
  endtask

  // Enter all-red, check the two-clock commit latency and single upd pulse, then leave.
  task automatic all_red(input string tag, input int na, input int nb);
    int oa;
    int ob;
    oa = exp_ca;
    ob = exp_cb;
    la = LAMP_R;
    lb = LAMP_R;
    @(negedge clk);
    check({tag, "_e0_upd"}, 32'(upd), 0);
    check({tag, "_e0_ca"}, 32'(ca), oa);
    @(negedge clk);
    check({tag, "_e1_upd"}, 32'(upd), 0);
    check({tag, "_e1_ca"}, 32'(ca), oa);
    check({tag, "_e1_cb"}, 32'(cb), ob);
    @(negedge clk);
    exp_ca = exp_dur(na, mode, DEF_A);
    exp_cb = exp_dur(nb, mode, DEF_B);
    check({tag, "_ca"}, 32'(ca), exp_ca);
    check({tag, "_cb"}, 32'(cb), exp_cb);
    check({tag, "_upd"}, 32'(upd), 1);
    @(negedge clk);
    check({tag, "_upd_off"}, 32'(upd), 0);
    la = LAMP_G;
    lb = LAMP_R;
    @(negedge clk);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int na;
    int nb;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ca", 32'(ca), DEF_A);
    check("rst_cb", 32'(cb), DEF_B);
    check("rst_upd", 32'(upd), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rel_ca", 32'(ca), DEF_A);
    check("rel_upd", 32'(upd), 0);
    all_red("empty", 0, 0);

    // Clean pulses, then hold through the following green
    pulses(1'b1, 5, 6, 9);
    pulses(1'b0, 2, 6, 9);
    all_red("basic", 5, 2);
    for (int i = 0; i < 3; i++) begin
      repeat (5) @(negedge clk);
      check("hold_ca", 32'(ca), 18);
      check("hold_cb", 32'(cb), 12);
      check("hold_upd", 32'(upd), 0);
    end

    // Clamp at MAX_G and counter saturation
    pulses(1'b1, 40, 6, 6);
    pulses(1'b0, 300, 6, 6);
    check("sat_cnt_b", 32'(dut.w_cnt_b), 255);
    all_red("clamp", 40, 300);

    // Fixed mode ignores demand
    mode = 1'b1;
    pulses(1'b1, 10, 6, 8);
    all_red("fixed", 10, 0);
    mode = 1'b0;

    // Two edges inside the holdoff window count once
    sa = 1'b1; @(negedge clk);
    sa = 1'b0; @(negedge clk);
    sa = 1'b1; @(negedge clk);
    sa = 1'b0;
    repeat (6) @(negedge clk);
    all_red("holdoff", 1, 0);

    // Edge landing in the snapshot clock goes to the next window
    sa = 1'b1;
    repeat (2) @(negedge clk);
    all_red("snap", 0, 0);
    sa = 1'b0;
    repeat (4) @(negedge clk);
    all_red("snap_next", 1, 0);

    // Reset during CALC abandons the computation
    pulses(1'b1, 2, 6, 8);
    la = LAMP_R;
    lb = LAMP_R;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rcalc_ca", 32'(ca), DEF_A);
    check("rcalc_cb", 32'(cb), DEF_B);
    check("rcalc_upd", 32'(upd), 0);
    la = LAMP_G;
    lb = LAMP_R;
    @(negedge clk);
    rst = 1'b1;
    exp_ca = DEF_A;
    exp_cb = DEF_B;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rrel_upd", 32'(upd), 0);
      check("rrel_ca", 32'(ca), DEF_A);
    end
    pulses(1'b1, 3, 6, 8);
    pulses(1'b0, 1, 6, 8);
    all_red("after_rst", 3, 1);

    // Randomized windows
    for (int it = 0; it < 6; it++) begin
      na   = int'($urandom_range(30, 0));
      nb   = int'($urandom_range(30, 0));
      mode = ($urandom_range(3, 0) == 0);
      pulses(1'b1, na, 6, 10);
      pulses(1'b0, nb, 6, 10);
      all_red("rand", na, nb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
